// File: rtl/moo_iv_rbk_if.sv
// Host readback stream of the IV chaining unit: request pulse, 32-bit
// valid/ready word stream with last marker, and a busy indication.
interface moo_iv_rbk_if;
  logic        rd_req;
  logic        rd_rdy;
  logic [31:0] rd_dat;
  logic        rd_vld;
  logic        rd_last;
  logic        rbk_busy;

  // host side
  modport master (output rd_req, rd_rdy, input rd_dat, rd_vld, rd_last, rbk_busy);
  // readback unit side
  modport slave  (input rd_req, rd_rdy, output rd_dat, rd_vld, rd_last, rbk_busy);
endinterface

// File: rtl/moo_iv_rbk.sv
// IV readback / chaining unit.
// Follows the chained IV block by block (mode-dependent rule) and, on a host
// request, freezes a snapshot and streams it MSW first as 32-bit words.
// Optional feature macro MOO_RBK_CNT_EN: appends a fifth word carrying the
// completed-block count captured together with the IV snapshot.
module moo_iv_rbk #(
  parameter int CNT_W     = 16,
  parameter bit BYTE_SWAP = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_core,
  input  logic [3:0]       moo_op,
  input  logic [127:0]     iv,
  input  logic             iv_ld,
  input  logic [127:0]     blk_di,
  input  logic [127:0]     blk_do,
  input  logic             blk_vld,
  moo_iv_rbk_if.slave      rd,
  output logic [127:0]     next_iv,
  output logic [CNT_W-1:0] blk_cnt
);

`ifdef MOO_RBK_CNT_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, SEND} st_t;

  st_t              state, state_nxt;
  logic [127:0]     iv_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [127:0]     snap;
  logic [2:0]       idx;
  logic             hs;
  logic [31:0]      word, word_o;
  logic             vld_o, last_o, busy_o;
`ifdef MOO_RBK_CNT_EN
  logic [CNT_W-1:0] cnt_snap;
`endif

  // Next chain value; also the value a same-cycle rd_req snapshots.
  always_comb begin
    iv_nxt  = next_iv;
    cnt_nxt = blk_cnt;
    if (iv_ld) begin
      iv_nxt  = iv;
      cnt_nxt = '0;
    end else if (blk_vld) begin
      case (moo_op[2:0])
        3'b010, 3'b100: iv_nxt = moo_op[3] ? blk_di : blk_do;   // CBC / CFB
        3'b011:         iv_nxt = blk_di ^ blk_do;               // OFB keystream
        3'b101, 3'b111: iv_nxt = {next_iv[127:32], next_iv[31:0] + 32'd1};
        3'b110:         iv_nxt = {next_iv[127:16], next_iv[15:0] + 16'd1};
        default:        iv_nxt = next_iv;                       // CMAC / ECB
      endcase
      if (blk_cnt != '1) cnt_nxt = blk_cnt + CNT_W'(1);
    end
  end

  // Chain register and block counter; clr_core wins over everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_iv <= '0;
      blk_cnt <= '0;
    end else if (clr_core) begin
      next_iv <= '0;
      blk_cnt <= '0;
    end else begin
      next_iv <= iv_nxt;
      blk_cnt <= cnt_nxt;
    end
  end

  assign hs = (state == SEND) && rd.rd_rdy;

  // Readout FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        state <= IDLE;
    else if (clr_core) state <= IDLE;
    else               state <= state_nxt;
  end

  // Readout FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd.rd_req) state_nxt = LOAD;
      LOAD:    state_nxt = SEND;
      SEND:    if (hs && idx == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot capture at request acceptance and word index advance on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap <= '0;
      idx  <= '0;
`ifdef MOO_RBK_CNT_EN
      cnt_snap <= '0;
`endif
    end else if (clr_core) begin
      snap <= '0;
      idx  <= '0;
`ifdef MOO_RBK_CNT_EN
      cnt_snap <= '0;
`endif
    end else begin
      if (state == IDLE && rd.rd_req) begin
        snap <= iv_nxt;
`ifdef MOO_RBK_CNT_EN
        cnt_snap <= cnt_nxt;
`endif
      end
      if (state == LOAD) idx <= '0;
      else if (hs)       idx <= idx + 3'd1;
    end
  end

  // Readout outputs; clr_core drops valid immediately so an aborted
  // transfer can never complete a handshake or flag rd_last.
  always_comb begin
    word = '0;
    case (idx)
      3'd0:    word = snap[127:96];
      3'd1:    word = snap[95:64];
      3'd2:    word = snap[63:32];
      3'd3:    word = snap[31:0];
`ifdef MOO_RBK_CNT_EN
      3'd4: begin
        word = '0;
        word[CNT_W-1:0] = cnt_snap;
      end
`endif
      default: word = '0;
    endcase
    busy_o = (state != IDLE);
    vld_o  = (state == SEND) && !clr_core;
    last_o = vld_o && (idx == LAST_IDX);
    word_o = '0;
    if (vld_o)
      word_o = BYTE_SWAP ? {word[7:0], word[15:8], word[23:16], word[31:24]} : word;
  end

  assign rd.rd_dat   = word_o;
  assign rd.rd_vld   = vld_o;
  assign rd.rd_last  = last_o;
  assign rd.rbk_busy = busy_o;

endmodule
